// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - control FSM for a shift-add multiplier datapath
//
// Purpose:
//   Sequences an external shift-add datapath through load, WIDTH add/shift
//   iterations and a result-hold phase with a valid/ready handshake.
//   Supports a synchronous abort and an asynchronous active-high reset.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   start       - request to begin a multiplication
//   start_ready - high in IDLE; a start is accepted when start & start_ready
//   abort       - synchronous cancel of any operation in progress
//   A0          - current multiplier LSB from the datapath
//   LOAD_A      - load multiplier register
//   LOAD_B      - load multiplicand register
//   LOAD_P      - load product register with the shifted partial sum
//   init_P      - clear product register
//   SHIFT_A     - shift multiplier register right
//   select      - add multiplicand (1) or zero (0) into the partial sum
//   busy        - high in any non-IDLE state
//   out_valid   - product is final and stable
//   out_ready   - consumer accepts the product
//   iter_cnt    - number of completed iterations

module shift_add_mult_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          start_ready,
  input  logic          abort,
  input  logic          A0,
  output logic          LOAD_A,
  output logic          LOAD_B,
  output logic          LOAD_P,
  output logic          init_P,
  output logic          SHIFT_A,
  output logic          select,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] iter_cnt_q, iter_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Every control output is decoded from state alone, except select which
  // passes A0 straight through while iterating so the add decision uses the
  // multiplier bit of the current cycle.
  always_comb begin
    state_d     = state_q;
    iter_cnt_d  = iter_cnt_q;
    start_ready = 1'b0;
    LOAD_A      = 1'b0;
    LOAD_B      = 1'b0;
    LOAD_P      = 1'b0;
    init_P      = 1'b0;
    SHIFT_A     = 1'b0;
    select      = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        // abort in IDLE blocks the start even though start_ready shows 1
        if (start && !abort) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        busy       = 1'b1;
        LOAD_A     = 1'b1;
        LOAD_B     = 1'b1;
        init_P     = 1'b1;
        iter_cnt_d = '0;
        state_d    = abort ? S_IDLE : S_ITER;
      end

      S_ITER: begin
        busy    = 1'b1;
        LOAD_P  = 1'b1;
        SHIFT_A = 1'b1;
        select  = A0;
        if (abort) begin
          state_d    = S_IDLE;
          iter_cnt_d = '0;
        end else begin
          iter_cnt_d = iter_cnt_q + 1'b1;
          if (iter_cnt_q == LAST_ITER) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort) begin
          state_d    = S_IDLE;
          iter_cnt_d = '0;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        iter_cnt_d = '0;
      end
    endcase
  end

  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - directed self-checking bench for shift_add_mult_ctrl

module tb_shift_add_mult_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          start_ready;
  logic          abort;
  logic          A0;
  logic          LOAD_A, LOAD_B, LOAD_P, init_P, SHIFT_A, select;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] iter_cnt;

  // 4-bit shift-add datapath driven by the controller
  logic [W-1:0]   a_in, b_in;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] p_q;
  logic [W:0]     sum;

  int checks = 0;
  int errors = 0;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .abort       (abort),
    .A0          (A0),
    .LOAD_A      (LOAD_A),
    .LOAD_B      (LOAD_B),
    .LOAD_P      (LOAD_P),
    .init_P      (init_P),
    .SHIFT_A     (SHIFT_A),
    .select      (select),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .iter_cnt    (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign A0 = a_q[0];

  always_comb begin
    sum = {1'b0, p_q[2*W-1:W]} + (select ? {1'b0, b_q} : {(W+1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (LOAD_A)       a_q <= a_in;
    else if (SHIFT_A) a_q <= a_q >> 1;
    if (LOAD_B)       b_q <= b_in;
    if (init_P)       p_q <= '0;
    else if (LOAD_P)  p_q <= {sum, p_q[W-1:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int   n;
  int   nvalid;
  logic bad;
  logic [2*W-1:0] prod;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0;
    #3;
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_controls",    32'({LOAD_A, LOAD_B, LOAD_P, init_P, SHIFT_A, select}), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_iter_cnt",    32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 13 x 11 with out_ready high
    a_in = 4'd13; b_in = 4'd11; start = 1'b1;
    check("s1_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("s1_load_ctrl", 32'({LOAD_A, LOAD_B, init_P, LOAD_P, SHIFT_A}), 32'b11100);
    check("s1_load_busy", 32'({busy, start_ready}), 32'b10);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("s1_iter_ctrl", 32'({LOAD_A, LOAD_B, init_P, LOAD_P, SHIFT_A}), 32'b00011);
        check("s1_iter_cnt0", 32'(iter_cnt), 32'd0);
        check("s1_select_1",  32'(select), 32'd1);
      end
      if (n == 2) check("s1_select_0", 32'(select), 32'd0);
    end
    check("s1_latency",   32'(n), 32'd5);
    check("s1_product",   32'(p_q), 32'h8F);
    check("s1_iter_cnt4", 32'(iter_cnt), 32'd4);
    check("s1_done_ctrl", 32'({LOAD_A, LOAD_B, LOAD_P, init_P, SHIFT_A, select}), 32'd0);
    @(negedge clk);
    check("s1_valid_clear", 32'(out_valid), 32'd0);
    check("s1_busy_clear",  32'(busy), 32'd0);

    // 15 x 15 with out_ready held low
    out_ready = 1'b0;
    do_start(4'd15, 4'd15);
    repeat (5) @(negedge clk);
    check("s2_valid",   32'(out_valid), 32'd1);
    check("s2_product", 32'(p_q), 32'hE1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || p_q !== 8'hE1 || start_ready !== 1'b0) bad = 1'b1;
    end
    check("s2_hold_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("s2_valid_clear", 32'(out_valid), 32'd0);

    // 0 x 9 then 7 x 0 back-to-back
    do_start(4'd0, 4'd9);
    repeat (5) @(negedge clk);
    check("s3a_valid",   32'(out_valid), 32'd1);
    check("s3a_product", 32'(p_q), 32'h00);
    a_in = 4'd7; b_in = 4'd0; start = 1'b1;
    @(negedge clk);
    check("s3_idle_ready", 32'({start_ready, busy}), 32'b10);
    @(negedge clk);
    start = 1'b0;
    check("s3_accept", 32'(LOAD_A), 32'd1);
    repeat (5) @(negedge clk);
    check("s3b_valid",   32'(out_valid), 32'd1);
    check("s3b_product", 32'(p_q), 32'h00);
    @(negedge clk);

    // abort while idle takes priority over start
    start = 1'b1; abort = 1'b1;
    check("s4_idle_abort_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("s4_idle_abort_busy", 32'(busy), 32'd0);

    // 9 x 5 aborted in the second iteration cycle
    do_start(4'd9, 4'd5);
    @(negedge clk);
    @(negedge clk);
    check("s4_iter_cnt1", 32'(iter_cnt), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s4_abort_idle", 32'({busy, out_valid, start_ready}), 32'b001);
    check("s4_abort_cnt",  32'(iter_cnt), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    check("s4_no_valid", 32'(bad), 32'd0);
    do_start(4'd3, 4'd4);
    repeat (5) @(negedge clk);
    check("s4_product", 32'(p_q), 32'h0C);
    @(negedge clk);

    // 6 x 7 interrupted by reset mid-iteration
    do_start(4'd6, 4'd7);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_rst_outputs", 32'({busy, out_valid, LOAD_A, LOAD_B, LOAD_P, init_P, SHIFT_A, select}), 32'd0);
    check("s5_rst_ready",   32'(start_ready), 32'd1);
    check("s5_rst_cnt",     32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("s5_idle_after_rst", 32'(bad), 32'd0);
    a_in = 4'd6; b_in = 4'd7; start = 1'b1;
    nvalid = 0; bad = 1'b0; prod = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy && start_ready) bad = 1'b1;
      if (out_valid) begin
        nvalid++;
        prod  = p_q;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("s5_ready_while_busy", 32'(bad), 32'd0);
    check("s5_valid_count",      32'(nvalid), 32'd1);
    check("s5_product",          32'(prod), 32'h2A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
